// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: shared widths, NOP encoding and fetch FSM state type.
package instruction_fetch_pkg;
    localparam int ADDR_W = 20;
    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_ENC = 32'h00000013;
    typedef enum logic {FETCH, WAIT} fetch_state_e;
endpackage

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: fetch PC register with word-aligned redirect and modulo +4 advance.
module fetch_pc_gen
    import instruction_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BOOT_ADDR = 20'h01000
) (
    input  logic              clk_i,
    input  logic              rsn_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    input  logic              advance_i,
    output logic [ADDR_W-1:0] pc_o
);
    logic [ADDR_W-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = redirect_i ? {redirect_pc_i[ADDR_W-1:2], 2'b00} :
               advance_i  ? pc_q + ADDR_W'(4) : pc_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rsn_i) pc_q <= BOOT_ADDR;
        else        pc_q <= pc_d;
    end

    assign pc_o = pc_q;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: FETCH/WAIT fetch stage feeding decode from the I-cache.
// Define FETCH_STALL_CNT_EN to add the stall_cnt_o cycle counter.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0]  BOOT_ADDR = 20'h01000,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_ENC
) (
    input  logic               clk_i,
    input  logic               rsn_i,
    output logic [ADDR_W-1:0]  icache_addr_o,
    input  logic [INSTR_W-1:0] icache_data_i,
    input  logic               icache_miss_i,
    output logic               icache_cancel_o,
    input  logic               redirect_i,
    input  logic [ADDR_W-1:0]  redirect_pc_i,
    input  logic               dec_stall_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  pc_o,
    output logic               valid_o
`ifdef FETCH_STALL_CNT_EN
    ,output logic [31:0]       stall_cnt_o
`endif
);
    fetch_state_e       state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_out_q, pc_out_d;
    logic               valid_q, valid_d;
    logic [ADDR_W-1:0]  pc;
    logic               advance;

    assign advance = !redirect_i && !dec_stall_i && !icache_miss_i;

    fetch_pc_gen #(.BOOT_ADDR(BOOT_ADDR)) u_pc_gen (
        .clk_i         (clk_i),
        .rsn_i         (rsn_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .advance_i     (advance),
        .pc_o          (pc)
    );

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        if (redirect_i) begin
            state_d = FETCH;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (!dec_stall_i) begin
            state_d  = icache_miss_i ? WAIT : FETCH;
            instr_d  = icache_miss_i ? NOP_INSTR : icache_data_i;
            pc_out_d = icache_miss_i ? pc_out_q : pc;
            valid_d  = !icache_miss_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            state_q  <= FETCH;
            instr_q  <= NOP_INSTR;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
        end
    end

    assign icache_addr_o   = pc;
    assign icache_cancel_o = redirect_i && state_q == WAIT;
    assign instr_o         = instr_q;
    assign pc_o            = pc_out_q;
    assign valid_o         = valid_q;

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    assign stall_cnt_d = stall_cnt_q + 32'(state_q == WAIT || dec_stall_i);

    always_ff @(posedge clk_i) begin
        if (!rsn_i) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt_o = stall_cnt_q;
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed checks; the I-cache returns {12'hA00, addr} as data.
module tb_instruction_fetch;
    logic        clk_i = 1'b0;
    logic        rsn_i = 1'b0;
    logic [19:0] icache_addr_o;
    logic [31:0] icache_data_i;
    logic        icache_miss_i = 1'b0;
    logic        icache_cancel_o;
    logic        redirect_i = 1'b0;
    logic [19:0] redirect_pc_i = '0;
    logic        dec_stall_i = 1'b0;
    logic [31:0] instr_o;
    logic [19:0] pc_o;
    logic        valid_o;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt_o;
`endif
    int total = 0;
    int bad = 0;

    always #5 clk_i = ~clk_i;

    assign icache_data_i = {12'hA00, icache_addr_o};

    instruction_fetch dut (
        .clk_i           (clk_i),
        .rsn_i           (rsn_i),
        .icache_addr_o   (icache_addr_o),
        .icache_data_i   (icache_data_i),
        .icache_miss_i   (icache_miss_i),
        .icache_cancel_o (icache_cancel_o),
        .redirect_i      (redirect_i),
        .redirect_pc_i   (redirect_pc_i),
        .dec_stall_i     (dec_stall_i),
        .instr_o         (instr_o),
        .pc_o            (pc_o),
        .valid_o         (valid_o)
`ifdef FETCH_STALL_CNT_EN
        ,.stall_cnt_o    (stall_cnt_o)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [19:0] pc, input logic [31:0] ins);
        chk({tag, ".valid"}, 32'(valid_o), 32'(v));
        chk({tag, ".pc"}, 32'(pc_o), 32'(pc));
        chk({tag, ".instr"}, instr_o, ins);
    endtask

    initial begin
        step();
        step();
        chk_out("reset", 1'b0, 20'h0, 32'h13);
        chk("reset.addr", 32'(icache_addr_o), 32'h01000);
        chk("reset.cancel", 32'(icache_cancel_o), 32'h0);

        rsn_i = 1'b1;
        step();
        chk_out("hit1", 1'b1, 20'h01000, 32'hA0001000);
        step();
        chk_out("hit2", 1'b1, 20'h01004, 32'hA0001004);
        step();
        chk_out("hit3", 1'b1, 20'h01008, 32'hA0001008);
        step();
        chk("hit4.addr", 32'(icache_addr_o), 32'h01010);

        icache_miss_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("miss.valid", 32'(valid_o), 32'h0);
            chk("miss.addr", 32'(icache_addr_o), 32'h01010);
        end
        icache_miss_i = 1'b0;
        step();
        chk_out("refill", 1'b1, 20'h01010, 32'hA0001010);
        chk("refill.addr", 32'(icache_addr_o), 32'h01014);

        icache_miss_i = 1'b1;
        step();
        redirect_i = 1'b1;
        redirect_pc_i = 20'h02003;
        #1;
        chk("wait.cancel", 32'(icache_cancel_o), 32'h1);
        step();
        redirect_i = 1'b0;
        icache_miss_i = 1'b0;
        #1;
        chk("redir.cancel_off", 32'(icache_cancel_o), 32'h0);
        chk("redir.addr", 32'(icache_addr_o), 32'h02000);
        chk_out("redir", 1'b0, 20'h01010, 32'h13);
        step();
        chk_out("redir.hit", 1'b1, 20'h02000, 32'hA0002000);

        dec_stall_i = 1'b1;
        icache_miss_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("stall", 1'b1, 20'h02000, 32'hA0002000);
            chk("stall.addr", 32'(icache_addr_o), 32'h02004);
        end
        icache_miss_i = 1'b0;
        redirect_i = 1'b1;
        redirect_pc_i = 20'hFFFFE;
        #1;
        chk("fetch.cancel", 32'(icache_cancel_o), 32'h0);
        step();
        redirect_i = 1'b0;
        dec_stall_i = 1'b0;
        chk("stall_redir.valid", 32'(valid_o), 32'h0);
        chk("stall_redir.addr", 32'(icache_addr_o), 32'hFFFFC);
        step();
        chk_out("wrap1", 1'b1, 20'hFFFFC, 32'hA00FFFFC);
        step();
        chk_out("wrap2", 1'b1, 20'h00000, 32'hA0000000);

        redirect_i = 1'b1;
        redirect_pc_i = 20'h03000;
        step();
        redirect_pc_i = 20'h04008;
        step();
        chk("b2b.valid", 32'(valid_o), 32'h0);
        redirect_i = 1'b0;
        step();
        chk_out("b2b", 1'b1, 20'h04008, 32'hA0004008);

        icache_miss_i = 1'b1;
        step();
        step();
        rsn_i = 1'b0;
        #1;
        chk("rst_wait.cancel", 32'(icache_cancel_o), 32'h0);
        step();
        chk_out("rst_wait", 1'b0, 20'h0, 32'h13);
        chk("rst_wait.addr", 32'(icache_addr_o), 32'h01000);
        rsn_i = 1'b1;
        redirect_i = 1'b1;
        redirect_pc_i = 20'h05000;
        #1;
        chk("rst_wait.fetch", 32'(icache_cancel_o), 32'h0);
        redirect_i = 1'b0;

`ifdef FETCH_STALL_CNT_EN
        rsn_i = 1'b0;
        step();
        chk("cnt.reset", stall_cnt_o, 32'h0);
        rsn_i = 1'b1;
        icache_miss_i = 1'b1;
        for (int i = 0; i < 4; i++) step();
        icache_miss_i = 1'b0;
        step();
        chk("cnt.miss", stall_cnt_o, 32'h4);
        chk("cnt.valid", 32'(valid_o), 32'h1);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter BOOT_ADDR, default 20'h01000, meaning PC loaded at reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h00000013, meaning instruction driven on instr_o when not valid.
REQ-003 SHALL have one clock and a synchronous, active-low reset, named as in the codebase: clk_i and rsn_i.
REQ-004 SHALL have clk_i  input  1  rising-edge clock for all state.
REQ-005 SHALL have rsn_i  input  1  synchronous active-low reset, sampled on clk_i.
REQ-006 SHALL have icache_addr_o  output  20  fetch address to the I-cache; equals pc_q.
REQ-007 SHALL have icache_data_i  input  32  instruction word from the I-cache.
REQ-008 SHALL have icache_miss_i  input  1  I-cache miss or fill in progress; data invalid.
REQ-009 SHALL have icache_cancel_o  output  1  abandon the outstanding line fill (drives cache cancel_wait).
REQ-010 SHALL have redirect_i  input  1  branch/jump/exception redirect from execute.
REQ-011 SHALL have redirect_pc_i  input  20  redirect target.
REQ-012 SHALL have dec_stall_i  input  1  decode cannot accept; hold outputs.
REQ-013 SHALL have instr_o  output  32  fetched instruction to decode (registered).
REQ-014 SHALL have pc_o  output  20  PC of instr_o (registered).
REQ-015 SHALL have valid_o  output  1  instr_o/pc_o hold a real instruction.

Function
REQ-016 SHALL use a two-state FSM: FETCH (cache hitting) and WAIT (miss outstanding).
REQ-017 SHALL apply per-cycle priority: reset > redirect_i > dec_stall_i > icache_miss_i > advance.
REQ-018 Advance (FETCH, no miss, no stall, no redirect): next edge instr_o<=icache_data_i, pc_o<=pc_q, valid_o<=1, pc_q<=pc_q+4; one-cycle fetch latency.
REQ-019 Miss in FETCH without stall/redirect: pc_q held, valid_o<=0, instr_o<=NOP_INSTR, state<=WAIT.
REQ-020 WAIT: pc_q held, valid_o<=0; when icache_miss_i deasserts the same cycle performs an advance and returns to FETCH.
REQ-021 dec_stall_i without redirect: instr_o, pc_o, valid_o, pc_q and state all held; the miss is re-evaluated once the stall clears.
REQ-022 redirect_i: pc_q<=redirect_pc_i with bits [1:0] forced to 0; valid_o<=0; instr_o<=NOP_INSTR; state<=FETCH; applies even when dec_stall_i is set.
REQ-023 icache_cancel_o SHALL be combinational, =redirect_i && state==WAIT; it is 0 in every other case.
REQ-024 PC arithmetic SHALL be 20-bit modulo; 20'hFFFFC+4 wraps to 20'h00000 silently.
REQ-025 Back-to-back redirects SHALL take the latest target; no instruction from a superseded target ever reaches valid_o.

Reset
REQ-026 With rsn_i low at an edge: pc_q=BOOT_ADDR, state=FETCH, valid_o=0, instr_o=NOP_INSTR, pc_o=0; icache_cancel_o=0 from that edge.
REQ-027 Reset mid-WAIT SHALL return to FETCH without asserting icache_cancel_o; the cache is reset by the same rsn_i.

Configuration
REQ-028 Macro FETCH_STALL_CNT_EN defined: adds output stall_cnt_o (32) counting cycles with state==WAIT or dec_stall_i; cleared by reset; wraps at 2^32.
REQ-029 Macro FETCH_STALL_CNT_EN undefined: no stall_cnt_o port and no counter logic.

Structure
REQ-030 The shared package SHALL hold the FSM state typedef (FETCH/WAIT), address width 20, instruction width 32 and the NOP encoding constant.
REQ-031 The PC register, increment and redirect mux SHALL live in sub-module fetch_pc_gen; the FSM and output registers stay in instruction_fetch.

Verification
REQ-032 Reset, then constant hits with data 32'hA; on cycles 1..3 pc_o=0x01000,0x01004,0x01008 and valid_o=1.
REQ-033 Miss at pc 0x01010 for 5 cycles: valid_o=0 for those cycles, icache_addr_o stable at 0x01010, then instr of 0x01010 appears with valid_o=1.
REQ-034 Redirect to 0x02003 during WAIT: icache_cancel_o=1 that cycle only, next icache_addr_o=0x02000, valid_o=0.
REQ-035 dec_stall_i held 3 cycles with valid_o=1: instr_o/pc_o unchanged; redirect arriving mid-stall clears valid_o next cycle.
REQ-036 Redirect to 0xFFFFC then hits: pc_o sequence 0xFFFFC, 0x00000; with FETCH_STALL_CNT_EN, 4 miss cycles give stall_cnt_o=4.
